// File: rtl/result_pipe_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : result_pipe_reg_if
//  Description : Handshake bundle for the elastic result pipeline. The
//                producer/consumer side uses the master modport, the
//                pipeline itself uses the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface result_pipe_reg_if #(
    parameter int N     = 4,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*N-1:0]       in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*N-1:0]       out_data;
    logic [OCC_W-1:0]     occupancy;
    logic [2*N-1:0]       last_result;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy,
        input  last_result
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy,
        output last_result
    );
endinterface
`default_nettype wire

// File: rtl/result_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : result_pipe_reg
//  Description : Elastic DEPTH-stage pipeline for 2N-bit results with a
//                valid/ready handshake, bubble collapsing, synchronous
//                flush, registered occupancy and a last-consumed-result
//                register. All state updates on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module result_pipe_reg #(
    parameter int N     = 4,
    parameter int DEPTH = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    result_pipe_reg_if.slave       pipe_if
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int W     = 2 * N;

    // Stage storage: index 0 is the input stage, DEPTH-1 the output stage.
    logic [W-1:0]     data_q  [DEPTH];
    logic [W-1:0]     data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [W-1:0]     last_result_q;
    logic [W-1:0]     last_result_d;

    // ready[i] is true when stage i may be loaded this cycle.
    logic [DEPTH:0]   ready;
    logic             in_fire;
    logic             out_fire;

    assign ready[DEPTH] = pipe_if.out_ready;

    // An empty stage always accepts, which is what closes bubbles while the
    // consumer stalls.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
        assign ready[gi] = ~valid_q[gi] | ready[gi+1];
    end

    assign pipe_if.in_ready = ready[0] & ~pipe_if.flush;
    assign in_fire          = pipe_if.in_valid & pipe_if.in_ready;
    assign out_fire         = valid_q[DEPTH-1] & pipe_if.out_ready;

    assign pipe_if.out_valid   = valid_q[DEPTH-1];
    assign pipe_if.out_data    = data_q[DEPTH-1];
    assign pipe_if.occupancy   = occ_q;
    assign pipe_if.last_result = last_result_q;

    // Next-state for every stage: shift forward where ready, hold otherwise,
    // clear everything on flush.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i]  = data_q[i];
            valid_d[i] = valid_q[i];
        end

        if (ready[0]) begin
            data_d[0]  = pipe_if.in_data;
            valid_d[0] = in_fire;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (ready[i]) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end

        if (pipe_if.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i]  = '0;
                valid_d[i] = 1'b0;
            end
        end
    end

    // Occupancy is computed from the next-state valid bits and registered,
    // so the output is a clean register rather than an adder tree.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // The last handed-off word is captured regardless of flush, since an
    // output handshake in a flush cycle still completes.
    always_comb begin
        last_result_d = last_result_q;
        if (out_fire) begin
            last_result_d = data_q[DEPTH-1];
        end
    end

    // Pipeline state register, falling-edge, asynchronous active-high reset.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q       <= '0;
            occ_q         <= '0;
            last_result_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q       <= valid_d;
            occ_q         <= occ_d;
            last_result_q <= last_result_d;
        end
    end
endmodule
`default_nettype wire
